// File: rtl/eight_by_four_divider.sv
// Unsigned 8-by-4 restoring divider, one quotient bit per cycle, MSB first.
// Optional divide-by-zero short-cut enabled by defining DIV_BY_ZERO_DETECT_EN.
module eight_by_four_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [4:0] pr;
  logic [7:0] shreg;
  logic [3:0] dvs;
  logic [2:0] cnt;
  logic       accept, last, fits;
  logic [4:0] rem_shift, rem_next;
  logic       zero_fast;

  assign accept = start && (state != CALC);

`ifdef DIV_BY_ZERO_DETECT_EN
  logic zero_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      zero_flag <= 1'b0;
    else if (accept) zero_flag <= (divisor == 4'd0);
  end

  assign zero_fast = zero_flag;
`else
  assign zero_fast = 1'b0;
`endif

  assign last = zero_fast || (cnt == 3'd7);

  // A carry into pr[4] only arises with a zero divisor, where every step fits anyway.
  always_comb begin
    rem_shift = {pr[3:0], shreg[7]};
    fits      = pr[4] || (rem_shift >= {1'b0, dvs});
    rem_next  = fits ? (rem_shift - {1'b0, dvs}) : rem_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // Shift register carries the unused dividend bits in from the top and
  // collects quotient bits at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr          <= 5'd0;
      shreg       <= 8'd0;
      dvs         <= 4'd0;
      cnt         <= 3'd0;
      quotient    <= 8'd0;
      remainder   <= 4'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      pr    <= 5'd0;
      shreg <= dividend;
      dvs   <= divisor;
      cnt   <= 3'd0;
    end else if (state == CALC) begin
      if (zero_fast) begin
        quotient    <= 8'hFF;
        remainder   <= shreg[3:0];
        div_by_zero <= 1'b1;
      end else begin
        pr    <= rem_next;
        shreg <= {shreg[6:0], fits};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          quotient    <= {shreg[6:0], fits};
          remainder   <= rem_next[3:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_eight_by_four_divider.sv
// Scoreboard bench for eight_by_four_divider: directed vectors plus a full operand sweep.
module tb_eight_by_four_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         at;
  } exp_t;

  exp_t sb[$];

  eight_by_four_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected result, written out from the arithmetic definition of division.
  task automatic push(input logic [7:0] a, input logic [3:0] b, input int k);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF;
      e.r = a[3:0];
`ifdef DIV_BY_ZERO_DETECT_EN
      e.z  = 1'b1;
      e.at = k + 1;
`else
      e.z  = 1'b0;
      e.at = k + 8;
`endif
    end else begin
      e.q  = a / {4'd0, b};
      e.r  = 4'(a % {4'd0, b});
      e.z  = 1'b0;
      e.at = k + 8;
    end
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.z));
        chk("done_cycle", cyc, e.at);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Issue one start pulse (we are at a falling edge) and wait for its result.
  task automatic divide(input logic [7:0] a, input logic [3:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    push(a, b, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    drain();
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    divide(8'd200, 4'd7);
    divide(8'd165, 4'd0);
    divide(8'd0, 4'd5);
    divide(8'd15, 4'd15);
    divide(8'd14, 4'd15);

    // Start held high: the second division is taken in the DONE cycle.
    start    = 1'b1;
    dividend = 8'd255;
    divisor  = 4'd1;
    k        = cyc + 1;
    push(8'd255, 4'd1, k);
    @(negedge clk);
    dividend = 8'd13;
    divisor  = 4'd15;
    push(8'd13, 4'd15, k + 9);
    while (cyc < k + 9) @(negedge clk);
    start = 1'b0;
    drain();

    // A second start during CALC must be ignored.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd3;
    k        = cyc + 1;
    push(8'd100, 4'd3, k);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 2) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd5;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Reset in the middle of CALC aborts the division without a done pulse.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd77;
    divisor  = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort_quotient", int'(quotient), 0);
    divide(8'd9, 4'd2);

    // Every operand pair.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        divide(8'(a), 4'(b));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle %0d limit reached", cyc);
    $fatal(1);
  end

endmodule
